mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 8, max consecutive DC grants while IC waits.
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rdy  in  1  global enable; low freezes all state.
REQ-005 SHALL have port flush  in  1  mispredict pulse (jp_wrong).
REQ-006 SHALL have ports ic_req/ic_addr[31:0]  in  ICache word-read request, level-held until ic_done.
REQ-007 SHALL have ports dc_req/dc_wr/dc_len[2:0]/dc_addr[31:0]/dc_wdata[31:0]  in  DCache request; dc_len is 1, 2 or 4 bytes.
REQ-008 SHALL have ports pf_req/pf_addr[31:0]  in  prefetch word-read request.
REQ-009 SHALL have ports ic_done, dc_done, pf_done  out  1 each, single-cycle completion pulses.
REQ-010 SHALL have port rdata  out  32  read data, valid with any done pulse.
REQ-011 SHALL have ports m_req, m_wr, m_len[2:0], m_addr[31:0], m_wdata[31:0]  out  request to byte-serial bus engine.
REQ-012 SHALL have ports m_done in 1 and m_rdata in 32  bus engine completion.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DRAIN.
REQ-014 IDLE: with any request, SHALL latch the winner and assert m_req the next cycle, entering BUSY.
REQ-015 Priority SHALL be DC > IC > PF.
REQ-016 When starve_cnt equals STARVE_LIM and ic_req is high, IC SHALL win over DC.
REQ-017 starve_cnt SHALL increment on each DC grant while ic_req is high, clear on IC grant, saturate at STARVE_LIM.
REQ-018 m_* outputs SHALL hold stable through BUSY; m_req SHALL drop the cycle after m_done.
REQ-019 On m_done in BUSY: SHALL pulse the owner's done with rdata=m_rdata, then return to IDLE.
REQ-020 Back-to-back grants: minimum one IDLE cycle between transactions.
REQ-021 On flush in IDLE: SHALL discard no state and grant no IC/PF request that cycle.
REQ-022 On flush in BUSY with IC/PF owner: SHALL enter DRAIN, wait for m_done, suppress the done pulse, then go IDLE.
REQ-023 Flush SHALL NOT affect a DC-owned transaction; stores are committed.
REQ-024 Simultaneous flush and m_done for an IC/PF owner: done SHALL be suppressed, next state IDLE.
REQ-025 Writes SHALL take m_wdata=dc_wdata; rdata for writes SHALL be 0.
REQ-026 rdy low SHALL hold state, counter and all outputs; done pulses SHALL not repeat.

Reset
REQ-027 rst SHALL force IDLE, starve_cnt=0, m_req=0, all done=0, rdata=0, m_addr/m_wdata/m_len/m_wr=0.
REQ-028 rst mid-BUSY SHALL abandon the transaction; no done pulse follows.

Configuration
REQ-029 With MEM_ARB_PF_EN defined, the PF port SHALL participate as lowest priority.
REQ-030 Without MEM_ARB_PF_EN, pf_req SHALL be ignored and pf_done SHALL be tied 0.

Structure
REQ-031 Owner encoding (OWN_DC, OWN_IC, OWN_PF) and FSM state enum SHALL live in the shared defines package.
REQ-032 Priority/starvation selection SHALL be one sub-module, mem_arb_pick.

Verification
REQ-033 ic_req+dc_req same cycle, addr 0x100/0x200 -> DC granted first (m_addr=0x200), IC next.
REQ-034 dc_req held high, ic_req waiting, STARVE_LIM=8 -> IC granted after 8th DC grant.
REQ-035 IC read of 0x40 in BUSY, flush, m_done 3 cycles later -> no ic_done, FSM IDLE.
REQ-036 DC store 0x30000, len 1, data 0x41, flush mid-transaction -> dc_done pulses, m_wdata=0x41 held.
REQ-037 rdy low 5 cycles during BUSY with m_done asserted then -> single dc_done after rdy returns.
REQ-038 Build without MEM_ARB_PF_EN, pf_req=1 only -> m_req stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared owner/state encodings for the memory arbiter
// Optional prefetch port is enabled with MEM_ARB_PF_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_DC = 2'd0,
        OWN_IC = 2'd1,
        OWN_PF = 2'd2
    } owner_e;

    localparam logic [2:0] LEN_WORD = 3'd4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - DC > IC > PF priority pick with IC anti-starvation override
// A flush cycle blocks IC/PF grants; DC stores may still be granted.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 8,
    parameter int CW         = 4
) (
    input  logic          dc_req_i,
    input  logic          ic_req_i,
    input  logic          pf_req_i,
    input  logic          flush_i,
    input  logic [CW-1:0] starve_cnt_i,
    output logic          gnt_o,
    output owner_e        owner_o
);

    logic starved;
    logic ic_ok;
    logic pf_ok;

    assign starved = ic_req_i && (starve_cnt_i == CW'(STARVE_LIM));
    assign ic_ok   = ic_req_i && !flush_i;
    assign pf_ok   = pf_req_i && !flush_i;

    always_comb begin
        gnt_o   = 1'b0;
        owner_o = OWN_DC;
        if (ic_ok && starved) begin
            gnt_o   = 1'b1;
            owner_o = OWN_IC;
        end else if (dc_req_i) begin
            gnt_o   = 1'b1;
            owner_o = OWN_DC;
        end else if (ic_ok) begin
            gnt_o   = 1'b1;
            owner_o = OWN_IC;
        end else if (pf_ok) begin
            gnt_o   = 1'b1;
            owner_o = OWN_PF;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - IC/DC/PF arbiter in front of a byte-serial bus engine
// Define MEM_ARB_PF_EN to let the prefetch port take part as lowest priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    input  logic        dc_req,
    input  logic        dc_wr,
    input  logic [2:0]  dc_len,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    input  logic        pf_req,
    input  logic [31:0] pf_addr,
    output logic        ic_done,
    output logic        dc_done,
    output logic        pf_done,
    output logic [31:0] rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_len,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_done,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_req_q, m_req_d;
    logic          m_wr_q, m_wr_d;
    logic [2:0]    m_len_q, m_len_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          ic_done_q, ic_done_d;
    logic          dc_done_q, dc_done_d;
    logic          pf_done_q, pf_done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          pend_q, pend_d;
    logic [31:0]   prdata_q, prdata_d;

    logic          pf_req_eff;
    logic          gnt;
    owner_e        gnt_owner;
    logic          done_ev;
    logic [31:0]   rsrc;

`ifdef MEM_ARB_PF_EN
    assign pf_req_eff = pf_req;
    assign pf_done    = pf_done_q;
`else
    logic pf_unused;
    assign pf_req_eff = 1'b0;
    assign pf_done    = 1'b0;
    assign pf_unused  = pf_req ^ pf_done_q;
`endif

    mem_arb_pick #(.STARVE_LIM(STARVE_LIM), .CW(CW)) u_pick (
        .dc_req_i     (dc_req),
        .ic_req_i     (ic_req),
        .pf_req_i     (pf_req_eff),
        .flush_i      (flush),
        .starve_cnt_i (cnt_q),
        .gnt_o        (gnt),
        .owner_o      (gnt_owner)
    );

    // An m_done seen while frozen is parked so it completes once rdy returns.
    assign done_ev = m_done || pend_q;
    assign rsrc    = pend_q ? prdata_q : m_rdata;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_wr_d    = m_wr_q;
        m_len_d   = m_len_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        ic_done_d = 1'b0;
        dc_done_d = 1'b0;
        pf_done_d = 1'b0;
        rdata_d   = rdata_q;
        pend_d    = pend_q;
        prdata_d  = prdata_q;
        if (rdy) begin
            pend_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt) begin
                        owner_d = gnt_owner;
                        m_req_d = 1'b1;
                        state_d = ST_BUSY;
                        case (gnt_owner)
                            OWN_DC: begin
                                m_wr_d    = dc_wr;
                                m_len_d   = dc_len;
                                m_addr_d  = dc_addr;
                                m_wdata_d = dc_wdata;
                                if (ic_req && (cnt_q != CW'(STARVE_LIM)))
                                    cnt_d = cnt_q + 1'b1;
                            end
                            OWN_IC: begin
                                m_wr_d    = 1'b0;
                                m_len_d   = LEN_WORD;
                                m_addr_d  = ic_addr;
                                m_wdata_d = 32'd0;
                                cnt_d     = '0;
                            end
                            default: begin
                                m_wr_d    = 1'b0;
                                m_len_d   = LEN_WORD;
                                m_addr_d  = pf_addr;
                                m_wdata_d = 32'd0;
                            end
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (done_ev) begin
                        m_req_d = 1'b0;
                        state_d = ST_IDLE;
                        if (owner_q == OWN_DC || !flush) begin
                            rdata_d = (owner_q == OWN_DC && m_wr_q) ? 32'd0 : rsrc;
                            case (owner_q)
                                OWN_DC:  dc_done_d = 1'b1;
                                OWN_IC:  ic_done_d = 1'b1;
                                default: pf_done_d = 1'b1;
                            endcase
                        end
                    end else if (flush && owner_q != OWN_DC) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (done_ev) begin
                        m_req_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && m_done && !pend_q) begin
            pend_d   = 1'b1;
            prdata_d = m_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_DC;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_len_q   <= 3'd0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            pf_done_q <= 1'b0;
            rdata_q   <= 32'd0;
            pend_q    <= 1'b0;
            prdata_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_len_q   <= m_len_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            ic_done_q <= ic_done_d;
            dc_done_q <= dc_done_d;
            pf_done_q <= pf_done_d;
            rdata_q   <= rdata_d;
            pend_q    <= pend_d;
            prdata_q  <= prdata_d;
        end
    end

    assign ic_done = ic_done_q;
    assign dc_done = dc_done_q;
    assign rdata   = rdata_q;
    assign m_req   = m_req_q;
    assign m_wr    = m_wr_q;
    assign m_len   = m_len_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb (default build)
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        ic_req, dc_req, dc_wr, pf_req;
    logic [31:0] ic_addr, dc_addr, dc_wdata, pf_addr;
    logic [2:0]  dc_len;
    logic        ic_done, dc_done, pf_done;
    logic [31:0] rdata;
    logic        m_req, m_wr;
    logic [2:0]  m_len;
    logic [31:0] m_addr, m_wdata;
    logic        m_done;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arb #(.STARVE_LIM(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_len(dc_len), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .pf_req(pf_req), .pf_addr(pf_addr),
        .ic_done(ic_done), .dc_done(dc_done), .pf_done(pf_done), .rdata(rdata),
        .m_req(m_req), .m_wr(m_wr), .m_len(m_len), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_rdata(m_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ic_req = 1'b0; ic_addr = 32'd0;
        dc_req = 1'b0; dc_wr = 1'b0; dc_len = 3'd0; dc_addr = 32'd0; dc_wdata = 32'd0;
        pf_req = 1'b0; pf_addr = 32'd0;
        m_done = 1'b0; m_rdata = 32'd0;
        tick(); tick();
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_dones", {29'd0, ic_done, dc_done, pf_done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_len_wr", {28'd0, m_len, m_wr}, 32'd0);
        rst = 1'b0;

        // Simultaneous IC and DC: DC first, then IC.
        ic_req = 1'b1; ic_addr = 32'h100;
        dc_req = 1'b1; dc_wr = 1'b0; dc_len = 3'd4; dc_addr = 32'h200;
        tick();
        chk("prio_dc_m_req", {31'd0, m_req}, 32'd1);
        chk("prio_dc_m_addr", m_addr, 32'h200);
        chk("prio_dc_m_len", {29'd0, m_len}, 32'd4);
        tick();
        chk("busy_hold_addr", m_addr, 32'h200);
        chk("busy_hold_req", {31'd0, m_req}, 32'd1);
        m_done = 1'b1; m_rdata = 32'hDEADBEEF;
        tick();
        chk("dc_done_pulse", {31'd0, dc_done}, 32'd1);
        chk("dc_rdata", rdata, 32'hDEADBEEF);
        chk("m_req_drop", {31'd0, m_req}, 32'd0);
        m_done = 1'b0; dc_req = 1'b0;
        tick();
        chk("prio_ic_m_addr", m_addr, 32'h100);
        chk("prio_ic_m_req", {31'd0, m_req}, 32'd1);
        chk("dc_done_single", {31'd0, dc_done}, 32'd0);
        m_done = 1'b1; m_rdata = 32'h11112222;
        tick();
        chk("ic_done_pulse", {31'd0, ic_done}, 32'd1);
        chk("ic_rdata", rdata, 32'h11112222);
        m_done = 1'b0; ic_req = 1'b0;
        tick();
        chk("idle_no_req", {31'd0, m_req}, 32'd0);

        // Starvation: eight DC grants, then IC, then DC again.
        dc_req = 1'b1; ic_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("starve_dc%0d_addr", i), m_addr, 32'h200);
            m_done = 1'b1;
            tick();
            chk($sformatf("starve_dc%0d_done", i), {31'd0, dc_done}, 32'd1);
            m_done = 1'b0;
        end
        tick();
        chk("starve_ic_addr", m_addr, 32'h100);
        m_done = 1'b1;
        tick();
        chk("starve_ic_done", {31'd0, ic_done}, 32'd1);
        m_done = 1'b0;
        tick();
        chk("starve_clr_dc", m_addr, 32'h200);
        m_done = 1'b1;
        tick();
        m_done = 1'b0; dc_req = 1'b0; ic_req = 1'b0;
        tick();

        // IC read flushed in BUSY; bus completes three cycles later.
        ic_req = 1'b1; ic_addr = 32'h40;
        tick();
        chk("flush_ic_addr", m_addr, 32'h40);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_req_held", {31'd0, m_req}, 32'd1);
        tick(); tick();
        m_done = 1'b1;
        tick();
        chk("drain_no_ic_done", {31'd0, ic_done}, 32'd0);
        chk("drain_m_req_drop", {31'd0, m_req}, 32'd0);
        m_done = 1'b0; ic_req = 1'b0;
        tick();
        chk("drain_idle", {30'd0, m_req, ic_done}, 32'd0);

        // Flush in IDLE blocks the IC grant that cycle only.
        ic_req = 1'b1; flush = 1'b1;
        tick();
        chk("idle_flush_no_grant", {31'd0, m_req}, 32'd0);
        flush = 1'b0;
        tick();
        chk("idle_after_flush_grant", {31'd0, m_req}, 32'd1);
        m_done = 1'b1; flush = 1'b1;
        tick();
        chk("flush_mdone_no_done", {31'd0, ic_done}, 32'd0);
        chk("flush_mdone_req_drop", {31'd0, m_req}, 32'd0);
        m_done = 1'b0; flush = 1'b0; ic_req = 1'b0;
        tick();
        chk("flush_mdone_idle", {31'd0, m_req}, 32'd0);

        // DC store survives a flush.
        dc_req = 1'b1; dc_wr = 1'b1; dc_len = 3'd1; dc_addr = 32'h30000; dc_wdata = 32'h41;
        tick();
        chk("st_m_wr", {31'd0, m_wr}, 32'd1);
        chk("st_m_len", {29'd0, m_len}, 32'd1);
        chk("st_m_addr", m_addr, 32'h30000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_wdata_held", m_wdata, 32'h41);
        chk("st_req_held", {31'd0, m_req}, 32'd1);
        m_done = 1'b1; m_rdata = 32'hFFFFFFFF;
        tick();
        chk("st_done", {31'd0, dc_done}, 32'd1);
        chk("st_rdata_zero", rdata, 32'd0);
        m_done = 1'b0; dc_req = 1'b0; dc_wr = 1'b0;
        tick();
        chk("st_done_off", {31'd0, dc_done}, 32'd0);

        // rdy low for five cycles with m_done arriving while frozen.
        dc_req = 1'b1; dc_len = 3'd2; dc_addr = 32'h500;
        tick();
        chk("rdy_m_len", {29'd0, m_len}, 32'd2);
        rdy = 1'b0;
        tick();
        m_done = 1'b1; m_rdata = 32'hCAFE0001;
        tick();
        chk("rdy_frozen_done0", {31'd0, dc_done}, 32'd0);
        m_done = 1'b0; m_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rdy_frozen_%0d", i), {30'd0, m_req, dc_done}, 32'd2);
        end
        rdy = 1'b1;
        tick();
        chk("rdy_done", {31'd0, dc_done}, 32'd1);
        chk("rdy_rdata", rdata, 32'hCAFE0001);
        dc_req = 1'b0;
        tick();
        chk("rdy_no_repeat", {31'd0, dc_done}, 32'd0);
        chk("rdy_req_drop", {31'd0, m_req}, 32'd0);

        // Prefetch ignored in the default build.
        pf_req = 1'b1; pf_addr = 32'h800;
        tick();
        chk("pf_ignored_1", {30'd0, m_req, pf_done}, 32'd0);
        tick();
        chk("pf_ignored_2", {30'd0, m_req, pf_done}, 32'd0);
        pf_req = 1'b0;

        // Reset mid-BUSY abandons the transaction.
        dc_req = 1'b1; dc_addr = 32'h900;
        tick();
        chk("rst_busy_grant", {31'd0, m_req}, 32'd1);
        rst = 1'b1; dc_req = 1'b0;
        #1;
        chk("rst_busy_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_busy_m_addr", m_addr, 32'd0);
        m_done = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy_no_done", {31'd0, dc_done}, 32'd0);
        m_done = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
